// File: rtl/csa_operand_accumulator.sv
// csa_operand_accumulator
//   Reduces a stream of unsigned operands into a registered carry-save pair
//   (sum vector, carry vector) using one 3:2 compressor row per accepted beat.
//   When the beat flagged last is taken, the pair is held for the downstream
//   carry-look-ahead adder until it is consumed.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   stage can accept a beat (state-only)
//   in_data    WIDTH-bit operand, zero-extended to ACC_W
//   in_last    final operand of the current group
//   out_valid  redundant result valid
//   out_ready  downstream consumes the result
//   out_sum    sum vector S
//   out_carry  carry vector C (already shifted left one bit)
//   out_count  operands in the group, saturating
//   out_ovf    group exceeded 2**GUARD operands
module csa_operand_accumulator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GUARD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+GUARD-1:0] out_sum,
  output logic [WIDTH+GUARD-1:0] out_carry,
  output logic [GUARD:0]         out_count,
  output logic                   out_ovf
);

  localparam int unsigned ACC_W    = WIDTH + GUARD;
  localparam int unsigned CNT_W    = GUARD + 1;
  localparam int unsigned OvfLimit = 2 ** GUARD;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_sum, r_carry;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;

  logic               w_beat;
  logic               w_clear;
  logic [ACC_W-1:0]   w_x;
  logic [ACC_W-1:0]   w_maj;
  logic [ACC_W-1:0]   w_sum_nxt, w_carry_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_ovf_nxt;

  assign in_ready  = (r_state != StDone);
  assign out_valid = (r_state == StDone);
  assign out_sum   = r_sum;
  assign out_carry = r_carry;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

  assign w_beat  = in_valid & in_ready;
  assign w_clear = (r_state == StDone) & out_ready;

  // 3:2 compressor row; the majority vector is shifted into carry weight and
  // its top bit is dropped, which keeps S+C exact modulo 2**ACC_W.
  assign w_x         = {{GUARD{1'b0}}, in_data};
  assign w_maj       = (r_sum & r_carry) | (r_sum & w_x) | (r_carry & w_x);
  assign w_sum_nxt   = r_sum ^ r_carry ^ w_x;
  assign w_carry_nxt = {w_maj[ACC_W-2:0], 1'b0};

  // Count saturates at all-ones so the overflow flag stays meaningful.
  assign w_count_nxt = (&r_count) ? r_count : r_count + 1'b1;
  assign w_ovf_nxt   = r_ovf | (32'(w_count_nxt) > OvfLimit);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle, StAccum: begin
        if (w_beat) w_state_nxt = in_last ? StDone : StAccum;
      end
      StDone: begin
        if (out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_sum   <= '0;
      r_carry <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_sum   <= '0;
        r_carry <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_beat) begin
        r_sum   <= w_sum_nxt;
        r_carry <= w_carry_nxt;
        r_count <= w_count_nxt;
        r_ovf   <= w_ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_csa_operand_accumulator.sv
module tb_csa_operand_accumulator;

  localparam int WIDTH = 8;
  localparam int GUARD = 4;
  localparam int ACC_W = WIDTH + GUARD;
  localparam int MOD   = 4096;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_last;
  logic [WIDTH-1:0] in_data;
  logic             out_valid, out_ready;
  logic [ACC_W-1:0] out_sum, out_carry;
  logic [GUARD:0]   out_count;
  logic             out_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int total;
    int count;
    int ovf;
    int exact;
    int sum;
    int carry;
  } exp_t;

  exp_t exp_q[$];

  csa_operand_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int total_now();
    return (int'(out_sum) + int'(out_carry)) % MOD;
  endfunction

  task automatic push_exp(input int total, input int count, input int ovf,
                          input int exact, input int sum, input int carry);
    exp_t e;
    e.total = total; e.count = count; e.ovf = ovf;
    e.exact = exact; e.sum = sum; e.carry = carry;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expected result per consumed output.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_total", total_now(), e.total);
        check("result_count", int'(out_count), e.count);
        check("result_ovf", int'(out_ovf), e.ovf);
        if (e.exact != 0) begin
          check("result_sum_exact", int'(out_sum), e.sum);
          check("result_carry_exact", int'(out_carry), e.carry);
        end
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    logic acc;
    int   cyc;
    acc = 1'b0;
    cyc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!acc && cyc < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      cyc++;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'hEE;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 30) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_sum", int'(out_sum), 0);
    check("reset_out_carry", int'(out_carry), 0);
    check("reset_out_count", int'(out_count), 0);
    check("reset_out_ovf", int'(out_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: 5 + 9 + 12 = 26, valid right after the last beat
    push_exp(26, 3, 0, 0, 0, 0);
    send(8'd5, 1'b0);
    send(8'd9, 1'b0);
    send(8'd12, 1'b1);
    check("t1_latency_valid", int'(out_valid), 1);
    check("t1_latency_in_ready", int'(in_ready), 0);
    drain();

    // 2: single operand leaves S=X, C=0
    push_exp(167, 1, 0, 1, 167, 0);
    send(8'hA7, 1'b1);
    drain();

    // 3: 16 x 255 = 4080 exact; 17 x 255 = 4335 -> 239 with overflow
    push_exp(4080, 16, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) send(8'hFF, (i == 15));
    drain();
    push_exp(239, 17, 1, 0, 0, 0);
    for (int i = 0; i < 17; i++) send(8'hFF, (i == 16));
    drain();

    // 4: backpressure in DONE with a held last beat
    out_ready = 1'b0;
    push_exp(5, 2, 0, 0, 0, 0);
    push_exp(7, 1, 0, 1, 7, 0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'd7;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_in_ready", int'(in_ready), 0);
      check("t4_hold_out_valid", int'(out_valid), 1);
      check("t4_hold_total", total_now(), 5);
      check("t4_hold_count", int'(out_count), 2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_clear_sum", int'(out_sum), 0);
    check("t4_clear_carry", int'(out_carry), 0);
    check("t4_clear_count", int'(out_count), 0);
    check("t4_clear_in_ready", int'(in_ready), 1);
    check("t4_clear_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t4_held_beat_valid", int'(out_valid), 1);
    drain();

    // 5: bubbles between beats; garbage data while in_valid=0 is ignored
    push_exp(15, 3, 0, 0, 0, 0);
    send(8'd3, 1'b0);
    in_data = 8'hEE;
    @(posedge clk);
    @(posedge clk);
    #1;
    send(8'd4, 1'b0);
    send(8'd8, 1'b1);
    drain();

    // 6: asynchronous reset mid-group discards it
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_sum", int'(out_sum), 0);
    check("t6_rst_carry", int'(out_carry), 0);
    check("t6_rst_count", int'(out_count), 0);
    check("t6_rst_in_ready", int'(in_ready), 1);
    check("t6_rst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(2, 2, 0, 0, 0, 0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
